// File: rtl/engine_dispatcher.sv
// engine_dispatcher: raster-sweeps a H_RES x V_RES grid, issues one GO/eDONE
// transaction per pixel to a Mandelbrot engine and writes each ItrCounter
// result to the frame RAM at y*H_RES+x.
// Ports:
//   Engine_CLK, eRST               clock, sync active-high reset
//   start, abort                   frame control levels
//   re_min, im_max, re_step,
//   im_step, max_itr               frame config, latched at frame start
//   eRegRe, eRegIm, eMaxItr, GO    engine request side
//   eDONE, ItrCounter              engine response side
//   ram_wr_en/addr/data            frame RAM write port
//   busy, frame_done               status
module engine_dispatcher #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              Engine_CLK,
    input  logic              eRST,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       re_min,
    input  logic [31:0]       im_max,
    input  logic [31:0]       re_step,
    input  logic [31:0]       im_step,
    input  logic [15:0]       max_itr,
    output logic [31:0]       eRegRe,
    output logic [31:0]       eRegIm,
    output logic [15:0]       eMaxItr,
    output logic              GO,
    input  logic              eDONE,
    input  logic [15:0]       ItrCounter,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [15:0]       ram_wr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RELEASE,
        S_ADVANCE,
        S_ABORT
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       re_q, re_d;
    logic [31:0]       im_q, im_d;
    logic [15:0]       mitr_q, mitr_d;
    logic [31:0]       re_min_q, re_min_d;
    logic [31:0]       re_step_q, re_step_d;
    logic [31:0]       im_step_q, im_step_d;
    logic              go_q, go_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              fdone_q, fdone_d;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        re_d      = re_q;
        im_d      = im_q;
        mitr_d    = mitr_q;
        re_min_d  = re_min_q;
        re_step_d = re_step_q;
        im_step_d = im_step_q;
        go_d      = go_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        fdone_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                re_min_d  = re_min;
                re_step_d = re_step;
                im_step_d = im_step;
                mitr_d    = max_itr;
                re_d      = re_min;
                im_d      = im_max;
                x_d       = '0;
                y_d       = '0;
                addr_d    = '0;
                state_d   = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                // Refuse to start while a stale DONE is still up
                go_d = 1'b0;
                if (!eDONE) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                go_d    = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (eDONE) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = ItrCounter;
                    go_d      = 1'b0;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!eDONE) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    fdone_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (x_q == X_LAST) begin
                        x_d  = '0;
                        y_d  = y_q + YW'(1);
                        re_d = re_min_q;
                        im_d = im_q - im_step_q;
                    end else begin
                        x_d  = x_q + XW'(1);
                        re_d = re_q + re_step_q;
                    end
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ABORT: begin
                go_d = 1'b0;
                if (!eDONE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a DONE seen this cycle
        if (abort && state_q != S_IDLE && state_q != S_ABORT) begin
            state_d   = S_ABORT;
            go_d      = 1'b0;
            wr_en_d   = 1'b0;
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
            fdone_d   = 1'b0;
        end
    end

    always_ff @(posedge Engine_CLK) begin
        if (eRST) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            re_q      <= '0;
            im_q      <= '0;
            mitr_q    <= '0;
            re_min_q  <= '0;
            re_step_q <= '0;
            im_step_q <= '0;
            go_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            re_q      <= re_d;
            im_q      <= im_d;
            mitr_q    <= mitr_d;
            re_min_q  <= re_min_d;
            re_step_q <= re_step_d;
            im_step_q <= im_step_d;
            go_q      <= go_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            fdone_q   <= fdone_d;
        end
    end

    assign eRegRe      = re_q;
    assign eRegIm      = im_q;
    assign eMaxItr     = mitr_q;
    assign GO          = go_q;
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign frame_done  = fdone_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_engine_dispatcher.sv
// tb_engine_dispatcher: directed tests for engine_dispatcher on a 4x3 grid
// with a behavioural engine answering x+10*y after 5 cycles.
module tb_engine_dispatcher;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 19;

    localparam logic [31:0] RE_MIN  = 32'hFE00_0000;
    localparam logic [31:0] RE_STEP = 32'h0040_0000;
    localparam logic [31:0] IM_MAX  = 32'h0100_0000;
    localparam logic [31:0] IM_STEP = 32'h0080_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   re_min = RE_MIN;
    logic [31:0]   im_max = IM_MAX;
    logic [31:0]   re_step = RE_STEP;
    logic [31:0]   im_step = IM_STEP;
    logic [15:0]   max_itr = 16'd100;
    logic [31:0]   eRegRe, eRegIm;
    logic [15:0]   eMaxItr;
    logic          GO, eDONE;
    logic [15:0]   ItrCounter;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [15:0]   ram_wr_data;
    logic          busy, frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    engine_dispatcher #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .Engine_CLK(clk), .eRST(rst), .start(start), .abort(abort),
        .re_min(re_min), .im_max(im_max), .re_step(re_step),
        .im_step(im_step), .max_itr(max_itr),
        .eRegRe(eRegRe), .eRegIm(eRegIm), .eMaxItr(eMaxItr),
        .GO(GO), .eDONE(eDONE), .ItrCounter(ItrCounter),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .busy(busy),
        .frame_done(frame_done)
    );

    // Engine model: derives the pixel from the coordinate it was given
    logic        eng_done = 1'b0;
    logic [15:0] eng_itr = 16'd0;
    int          eng_cnt = 0;
    logic        stale = 1'b0;

    function automatic logic [15:0] calc(input logic [31:0] re,
                                         input logic [31:0] im);
        int ex, ey;
        ex = int'($signed(re - RE_MIN)) >>> 22;
        ey = int'($signed(IM_MAX - im)) >>> 23;
        return 16'(ex + 10 * ey);
    endfunction

    always @(posedge clk) begin
        if (!eng_done) begin
            if (GO) begin
                if (eng_cnt == 4) begin
                    eng_done <= 1'b1;
                    eng_itr  <= calc(eRegRe, eRegIm);
                    eng_cnt  <= 0;
                end else begin
                    eng_cnt <= eng_cnt + 1;
                end
            end else begin
                eng_cnt <= 0;
            end
        end else if (!GO) begin
            eng_done <= 1'b0;
        end
    end

    assign eDONE      = eng_done | stale;
    assign ItrCounter = stale ? 16'hDEAD : eng_itr;

    // Write / frame_done log
    int            wr_n = 0;
    int            fd_n = 0;
    int            fd_at_wr = 0;
    logic [AW-1:0] log_addr [256];
    logic [15:0]   log_data [256];
    logic [31:0]   log_re   [256];
    logic [31:0]   log_im   [256];

    always @(negedge clk) begin
        if (ram_wr_en) begin
            if (wr_n < 256) begin
                log_addr[wr_n] <= ram_wr_addr;
                log_data[wr_n] <= ram_wr_data;
                log_re[wr_n]   <= eRegRe;
                log_im[wr_n]   <= eRegIm;
            end
            wr_n <= wr_n + 1;
        end
        if (frame_done) begin
            fd_n     <= fd_n + 1;
            fd_at_wr <= wr_n;
        end
    end

    logic [31:0] re_tab [4] = '{32'hFE00_0000, 32'hFE40_0000,
                                32'hFE80_0000, 32'hFEC0_0000};
    logic [31:0] im_tab [3] = '{32'h0100_0000, 32'h0080_0000,
                                32'h0000_0000};
    logic [15:0] dat_tab [12] = '{16'd0, 16'd1, 16'd2, 16'd3,
                                  16'd10, 16'd11, 16'd12, 16'd13,
                                  16'd20, 16'd21, 16'd22, 16'd23};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int fd0, input string nm);
        int n = 0;
        while (fd_n == fd0 && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: timeout, frame_done count %0d required > %0d",
                     nm, fd_n, fd0);
        end
        repeat (3) tick();
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b required 0 (timeout)", nm, busy);
        end
    endtask

    task automatic check_frame(input int w0, input string nm);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (log_addr[w0+i] !== AW'(i) ||
                log_data[w0+i] !== dat_tab[i] ||
                log_re[w0+i] !== re_tab[i%4] ||
                log_im[w0+i] !== im_tab[i/4]) begin
                errors++;
                $display("FAIL %s[%0d]: addr=%0d data=%0d re=%h im=%h required %0d %0d %h %h",
                         nm, i, log_addr[w0+i], log_data[w0+i],
                         log_re[w0+i], log_im[w0+i], i, dat_tab[i],
                         re_tab[i%4], im_tab[i/4]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({GO, busy, ram_wr_en, frame_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: GO,busy,wr_en,fdone=%b required 0000",
                     {GO, busy, ram_wr_en, frame_done});
        end
        checks++;
        if (eRegRe !== 32'd0 || eRegIm !== 32'd0 || eMaxItr !== 16'd0) begin
            errors++;
            $display("FAIL reset_coord: re=%h im=%h mitr=%h required 0",
                     eRegRe, eRegIm, eMaxItr);
        end
        checks++;
        if (ram_wr_addr !== '0 || ram_wr_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_ram: addr=%h data=%h required 0",
                     ram_wr_addr, ram_wr_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_frame();
        int w0 = wr_n;
        int f0 = fd_n;
        pulse_start();
        wait_frame(f0, "frame");
        checks++;
        if (wr_n - w0 !== 12 || fd_n - f0 !== 1) begin
            errors++;
            $display("FAIL frame_count: writes=%0d fdone=%0d required 12 1",
                     wr_n - w0, fd_n - f0);
        end
        checks++;
        if (fd_at_wr !== w0 + 12) begin
            errors++;
            $display("FAIL frame_done_pos: after %0d writes required %0d",
                     fd_at_wr - w0, 12);
        end
        check_frame(w0, "frame");
        checks++;
        if (busy !== 1'b0 || eMaxItr !== 16'd100) begin
            errors++;
            $display("FAIL frame_end: busy=%b mitr=%0d required 0 100",
                     busy, eMaxItr);
        end
    endtask

    task automatic test_midframe_cfg();
        int w0 = wr_n;
        int f0 = fd_n;
        int n = 0;
        pulse_start();
        while (wr_n - w0 < 2 && n < 500) begin
            tick();
            n++;
        end
        re_min  = 32'h0000_0000;
        max_itr = 16'd7;
        checks++;
        if (eMaxItr !== 16'd100) begin
            errors++;
            $display("FAIL cfg_mitr_mid: mitr=%0d required 100", eMaxItr);
        end
        wait_frame(f0, "cfg");
        check_frame(w0, "cfg");
        checks++;
        if (eMaxItr !== 16'd100) begin
            errors++;
            $display("FAIL cfg_mitr_end: mitr=%0d required 100", eMaxItr);
        end
        pulse_start();
        tick();
        checks++;
        if (eMaxItr !== 16'd7 || eRegRe !== 32'd0) begin
            errors++;
            $display("FAIL cfg_reload: mitr=%0d re=%h required 7 0",
                     eMaxItr, eRegRe);
        end
        abort = 1'b1;
        wait_idle("cfg_abort");
        abort = 1'b0;
        re_min  = RE_MIN;
        max_itr = 16'd100;
        tick();
    endtask

    task automatic test_abort();
        int w0 = wr_n;
        int f0 = fd_n;
        int n = 0;
        pulse_start();
        while (!(wr_n - w0 == 5 && eDONE) && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (eRegRe !== 32'hFE40_0000 || eRegIm !== 32'h0080_0000) begin
            errors++;
            $display("FAIL abort_pix5: re=%h im=%h required fe400000 00800000",
                     eRegRe, eRegIm);
        end
        abort = 1'b1;
        tick();
        checks++;
        if (GO !== 1'b0 || ram_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_go: GO=%b wr_en=%b required 0 0",
                     GO, ram_wr_en);
        end
        wait_idle("abort_idle");
        checks++;
        if (eDONE !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: eDONE=%b required 0", eDONE);
        end
        abort = 1'b0;
        repeat (5) tick();
        checks++;
        if (wr_n - w0 !== 5 || fd_n !== f0 || log_addr[wr_n-1] !== AW'(4)) begin
            errors++;
            $display("FAIL abort_writes: writes=%0d fdone=%0d last=%0d required 5 0 4",
                     wr_n - w0, fd_n - f0, log_addr[wr_n-1]);
        end
    endtask

    task automatic test_stale_done();
        int w0 = wr_n;
        int gos = 0;
        int n = 0;
        stale = 1'b1;
        pulse_start();
        repeat (8) begin
            tick();
            if (GO !== 1'b0) gos++;
        end
        checks++;
        if (gos !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_go: GO high %0d cycles busy=%b required 0 1",
                     gos, busy);
        end
        stale = 1'b0;
        while (wr_n == w0 && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (wr_n == w0 || log_addr[w0] !== '0 || log_data[w0] !== 16'd0) begin
            errors++;
            $display("FAIL stale_first: addr=%0d data=%h required 0 0000",
                     log_addr[w0], log_data[w0]);
        end
        abort = 1'b1;
        wait_idle("stale_abort");
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        pulse_start();
        while (GO !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if (GO !== 1'b0 || busy !== 1'b0 || ram_wr_en !== 1'b0 ||
            eRegRe !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: GO=%b busy=%b wr_en=%b re=%h required 0 0 0 0",
                     GO, busy, ram_wr_en, eRegRe);
        end
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int w0 = wr_n;
        int f0 = fd_n;
        int n = 0;
        start = 1'b1;
        while (frame_done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: fdone=%b busy=%b required 0 1",
                     frame_done, busy);
        end
        start = 1'b0;
        wait_frame(f0 + 1, "b2b");
        checks++;
        if (wr_n - w0 !== 24 || fd_n - f0 !== 2) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d fdone=%0d required 24 2",
                     wr_n - w0, fd_n - f0);
        end
        check_frame(w0 + 12, "b2b");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_midframe_cfg();
        test_abort();
        test_stale_done();
        test_reset_mid();
        test_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
